lpc_residual_filter: RTL

//  Downstream of the Durbin coefficient store: captures the serial stream of quantised LPC

---
 rtl/lpc_residual_filter_if.sv | 35 +++
 rtl/lpc_residual_filter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lpc_residual_filter_if.sv
// Handshake/data bundle between the LPC residual filter and its producer/consumer.
// master drives samples, coefficients and control; slave is the filter itself.
interface lpc_residual_filter_if #(
  parameter int SAMPLE_W = 16,
  parameter int COEFF_W  = 12,
  parameter int RES_W    = 17
);
  logic                       iEnable;
  logic                       iStart;
  logic [3:0]                 iOrder;
  logic [4:0]                 iShift;
  logic [15:0]                iBlockSize;
  logic signed [COEFF_W-1:0]  iCoeff;
  logic                       iCoeffValid;
  logic signed [SAMPLE_W-1:0] iSample;
  logic                       iSampleValid;
  logic                       oReady;
  logic signed [RES_W-1:0]    oResidual;
  logic                       oValid;
  logic                       oWarmup;
  logic                       oDone;
  logic                       oError;

  modport master (
    output iEnable, iStart, iOrder, iShift, iBlockSize, iCoeff, iCoeffValid,
           iSample, iSampleValid,
    input  oReady, oResidual, oValid, oWarmup, oDone, oError
  );

  modport slave (
    input  iEnable, iStart, iOrder, iShift, iBlockSize, iCoeff, iCoeffValid,
           iSample, iSampleValid,
    output oReady, oResidual, oValid, oWarmup, oDone, oError
  );
endinterface

// File: rtl/lpc_residual_filter.sv
// Loads M quantised LPC coefficients, then streams one block through a 2-stage FIR predictor
// emitting residuals. Optional macro RESIDUAL_SAT_EN saturates instead of wrapping the residual.
module lpc_residual_filter #(
  parameter int SAMPLE_W  = 16,
  parameter int COEFF_W   = 12,
  parameter int MAX_ORDER = 12,
  parameter int RES_W     = 17
) (
  input logic                 iClock,
  input logic                 iReset,
  lpc_residual_filter_if.slave bus
);
  localparam int PROD_W = COEFF_W + SAMPLE_W;
  localparam int ACC_W  = PROD_W + 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]                 state;
  logic [3:0]                 order;
  logic [4:0]                 shift;
  logic [15:0]                block_size;
  logic [15:0]                count;
  logic [3:0]                 k;
  logic signed [COEFF_W-1:0]  coeff [1:MAX_ORDER];
  logic signed [SAMPLE_W-1:0] hist  [1:MAX_ORDER];
  logic signed [PROD_W-1:0]   prod  [1:MAX_ORDER];
  logic signed [SAMPLE_W-1:0] x1;
  logic                       v1;
  logic                       warm1;
  logic                       last1;
  logic                       accept;
  logic signed [ACC_W-1:0]    acc;
  logic signed [RES_W-1:0]    res;

  assign accept     = bus.iEnable && (state == S_RUN) && bus.iSampleValid;
  assign bus.oReady = (state == S_RUN);

  // Stage 2 datapath: sum of stage-1 products, arithmetic shift, subtract, reduce to RES_W.
  always_comb begin
    acc = '0;
    for (int i = 1; i <= MAX_ORDER; i++) acc = acc + ACC_W'(prod[i]);
`ifdef RESIDUAL_SAT_EN
    begin
      logic signed [ACC_W:0] diff;
      diff = (ACC_W + 1)'(x1) - (ACC_W + 1)'(acc >>> shift);
      res  = diff[RES_W-1:0];
      if (diff[ACC_W:RES_W-1] != {(ACC_W - RES_W + 2){diff[ACC_W]}})
        res = diff[ACC_W] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
    end
`else
    res = RES_W'(x1) - RES_W'(acc >>> shift);
`endif
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state         <= S_IDLE;
      order         <= '0;
      shift         <= '0;
      block_size    <= '0;
      count         <= '0;
      k             <= '0;
      x1            <= '0;
      v1            <= 1'b0;
      warm1         <= 1'b0;
      last1         <= 1'b0;
      for (int i = 1; i <= MAX_ORDER; i++) begin
        coeff[i] <= '0;
        hist[i]  <= '0;
        prod[i]  <= '0;
      end
      bus.oResidual <= '0;
      bus.oValid    <= 1'b0;
      bus.oWarmup   <= 1'b0;
      bus.oDone     <= 1'b0;
      bus.oError    <= 1'b0;
    end else if (bus.iEnable) begin
      bus.oError <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.iStart) begin
            if (int'(bus.iOrder) > MAX_ORDER) begin
              bus.oError <= 1'b1;
            end else begin
              order      <= bus.iOrder;
              shift      <= bus.iShift;
              block_size <= bus.iBlockSize;
              count      <= '0;
              k          <= 4'd1;
              for (int i = 1; i <= MAX_ORDER; i++) hist[i] <= '0;
              state      <= (bus.iOrder == 4'd0) ? S_RUN : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bus.iCoeffValid) begin
            coeff[k] <= bus.iCoeff;
            k        <= k + 4'd1;
            if (k == order) state <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept && (count == block_size - 16'd1)) state <= S_DRAIN;
        end
        default: state <= S_IDLE;
      endcase

      // Stage 1: products against the history as it stood before this sample.
      v1 <= accept;
      if (accept) begin
        x1    <= bus.iSample;
        warm1 <= (count < {12'd0, order});
        last1 <= (count == block_size - 16'd1);
        count <= count + 16'd1;
        for (int i = 1; i <= MAX_ORDER; i++)
          prod[i] <= (4'(i) <= order) ? PROD_W'(coeff[i]) * PROD_W'(hist[i]) : '0;
        hist[1] <= bus.iSample;
        for (int i = 2; i <= MAX_ORDER; i++) hist[i] <= hist[i-1];
      end

      bus.oValid  <= v1;
      bus.oWarmup <= v1 && warm1;
      bus.oDone   <= v1 && last1;
      if (v1) bus.oResidual <= warm1 ? RES_W'(x1) : res;
    end else begin
      // Stalled: data holds, but qualifiers must not repeat a pulse already seen.
      bus.oValid  <= 1'b0;
      bus.oWarmup <= 1'b0;
      bus.oDone   <= 1'b0;
      bus.oError  <= 1'b0;
    end
  end
endmodule
